// File: rtl/multi_stepper_ctrl.sv
// Multi-axis step/dir pulse generator with per-axis signed position tracking, all axes started by one trigger.
// Latency: dir valid 1 cycle after trigger, first step DIR_SETUP_CYCLES later, done 1 cycle after the slowest axis ends.
// Backpressure: none; en=0 freezes the move in place, abort ends it early with a done strobe.

module multi_stepper_ctrl #(
  parameter int NUM_AXES         = 2,
  parameter int PULSE_NUM_BITS   = 16,
  parameter int PULSE_WIDTH_BITS = 16,
  parameter int POS_BITS         = 24,
  parameter int DIR_SETUP_CYCLES = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 trigger,
  input  logic                                 abort,
  input  logic [NUM_AXES*PULSE_NUM_BITS-1:0]   pulse_num,
  input  logic [NUM_AXES*PULSE_WIDTH_BITS-1:0] pulse_width,
  input  logic                                 pos_clear,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_AXES-1:0]                  out,
  output logic [NUM_AXES-1:0]                  dir,
  output logic [NUM_AXES*POS_BITS-1:0]         position
);

  localparam int SC_BITS = $clog2(DIR_SETUP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t state, state_next;

  logic [SC_BITS-1:0]          setup_cnt;
  logic [PULSE_NUM_BITS-1:0]   remaining [NUM_AXES];
  logic [PULSE_WIDTH_BITS-1:0] width     [NUM_AXES];
  logic [PULSE_WIDTH_BITS-1:0] phase_cnt [NUM_AXES];
  logic [NUM_AXES-1:0]         low;
  logic [POS_BITS-1:0]         pos       [NUM_AXES];

  logic [PULSE_NUM_BITS-1:0]   num_in    [NUM_AXES];
  logic [PULSE_NUM_BITS-1:0]   abs_in    [NUM_AXES];
  logic [PULSE_WIDTH_BITS-1:0] width_in  [NUM_AXES];
  logic [POS_BITS-1:0]         pos_step  [NUM_AXES];
  logic [NUM_AXES-1:0]         hi_end, lo_end, active_next;
  logic                        all_zero, setup_end, start;

  // Slice the flat input buses per axis and derive step magnitudes
  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      num_in[i]   = pulse_num[i*PULSE_NUM_BITS +: PULSE_NUM_BITS];
      width_in[i] = pulse_width[i*PULSE_WIDTH_BITS +: PULSE_WIDTH_BITS];
      // Negation in PULSE_NUM_BITS unsigned: the most-negative count maps to 2^(N-1)
      abs_in[i]   = num_in[i][PULSE_NUM_BITS-1] ? (~num_in[i] + PULSE_NUM_BITS'(1)) : num_in[i];
    end
  end

  // Per-axis phase-end detection, lookahead of which axes stay active, position step
  always_comb begin
    hi_end      = '0;
    lo_end      = '0;
    active_next = '0;
    all_zero    = 1'b1;
    for (int i = 0; i < NUM_AXES; i++) begin
      pos_step[i]    = '0;
      hi_end[i]      = out[i] && (phase_cnt[i] == width[i] - PULSE_WIDTH_BITS'(1));
      lo_end[i]      = low[i] && (phase_cnt[i] == width[i] - PULSE_WIDTH_BITS'(1));
      // An axis in its final low phase drops out once that phase completes
      active_next[i] = out[i] || (low[i] && !(lo_end[i] && (remaining[i] == '0)));
      if (remaining[i] != '0) all_zero = 1'b0;
      if (state == RUN && en && !abort && hi_end[i])
        pos_step[i] = dir[i] ? '1 : POS_BITS'(1);
    end
  end

  assign setup_end = (setup_cnt == SC_BITS'(DIR_SETUP_CYCLES - 1));
  assign start     = (state == IDLE) && trigger && en;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && en) state_next = SETUP;
      end
      SETUP: begin
        busy = 1'b1;
        if (abort)                  state_next = DONE;
        else if (en && setup_end)   state_next = all_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort)                          state_next = DONE;
        else if (en && active_next == '0)   state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Direction-setup delay counter, counts enabled SETUP cycles only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                setup_cnt <= '0;
    else if (start)                           setup_cnt <= '0;
    else if (state == SETUP && en && !abort)  setup_cnt <= setup_cnt + SC_BITS'(1);
  end

  // Per-axis latch on trigger, then high/low phase sequencing during RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir <= '0;
      out <= '0;
      low <= '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        remaining[i] <= '0;
        width[i]     <= '0;
        phase_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_AXES; i++) begin
        case (state)
          IDLE: begin
            if (trigger && en) begin
              dir[i]       <= num_in[i][PULSE_NUM_BITS-1];
              remaining[i] <= abs_in[i];
              width[i]     <= (width_in[i] == '0) ? PULSE_WIDTH_BITS'(1) : width_in[i];
              phase_cnt[i] <= '0;
              low[i]       <= 1'b0;
              out[i]       <= 1'b0;
            end
          end
          SETUP: begin
            // First step edge coincides with the first RUN cycle
            if (!abort && en && setup_end) begin
              out[i]       <= (remaining[i] != '0);
              phase_cnt[i] <= '0;
            end
          end
          RUN: begin
            if (abort) begin
              out[i] <= 1'b0;
              low[i] <= 1'b0;
            end else if (en) begin
              if (hi_end[i]) begin
                out[i]       <= 1'b0;
                low[i]       <= 1'b1;
                phase_cnt[i] <= '0;
                remaining[i] <= remaining[i] - PULSE_NUM_BITS'(1);
              end else if (lo_end[i]) begin
                low[i]       <= 1'b0;
                out[i]       <= (remaining[i] != '0);
                phase_cnt[i] <= '0;
              end else if (out[i] || low[i]) begin
                phase_cnt[i] <= phase_cnt[i] + PULSE_WIDTH_BITS'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Position accumulators: clear applies first, then this cycle's step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_AXES; i++) pos[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_AXES; i++)
        pos[i] <= (pos_clear ? '0 : pos[i]) + pos_step[i];
    end
  end

  // Flatten positions onto the output bus
  always_comb begin
    position = '0;
    for (int i = 0; i < NUM_AXES; i++)
      position[i*POS_BITS +: POS_BITS] = pos[i];
  end

endmodule

// File: doc/multi_stepper_ctrl.md
Name: multi_stepper_ctrl

Overview:
Parametrised multi-axis stepper pulse controller, successor to the single-axis controller in the processor path. Accepts one signed step count and one pulse width per axis and starts all axes together on one trigger. Drives step/direction pins with a programmable direction-setup delay and tracks a signed absolute position per axis. Supports abort and pause (via en), and reports completion when the slowest axis finishes.

Parameters:
NUM_AXES, 2, number of independent stepper channels.
PULSE_NUM_BITS, 16, width of signed per-axis step count (two's complement).
PULSE_WIDTH_BITS, 16, width of per-axis half-period in clk cycles.
POS_BITS, 24, width of signed per-axis position accumulator (must be >= PULSE_NUM_BITS).
DIR_SETUP_CYCLES, 4, cycles dir is held stable before the first step edge (>=1).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
en  input  1  module enable; low = pause.
trigger  input  1  start command; sampled only in IDLE with en=1.
abort  input  1  terminates the active move.
pulse_num  input  NUM_AXES*PULSE_NUM_BITS  signed step counts; axis i at [i*PULSE_NUM_BITS +: PULSE_NUM_BITS].
pulse_width  input  NUM_AXES*PULSE_WIDTH_BITS  unsigned half-periods per axis.
pos_clear  input  1  zeroes all position accumulators.
busy  output  1  high while a move is in SETUP or RUN.
done  output  1  one-cycle completion strobe.
out  output  NUM_AXES  step pulse per axis.
dir  output  NUM_AXES  direction per axis; 1 = negative count.
position  output  NUM_AXES*POS_BITS  signed position per axis.

Behaviour:
- Reset, asynchronous: state=IDLE; out, dir, busy, done = 0; position = 0; all internal counters = 0.
- States: IDLE, SETUP, RUN, DONE.
- IDLE -> SETUP on the edge where trigger=1 and en=1. At that edge the block latches every axis: dir[i] = sign bit; remaining[i] = |pulse_num[i]| (PULSE_NUM_BITS unsigned, so the most-negative value gives 2^(PULSE_NUM_BITS-1) steps); width[i] = max(pulse_width[i], 1).
- Trigger asserted outside IDLE is ignored; later changes to pulse_num/pulse_width do not affect a running move.
- SETUP lasts exactly DIR_SETUP_CYCLES enabled cycles with out=0, then goes to RUN. If every remaining=0, SETUP goes to DONE instead.
- RUN: each axis with remaining>0 emits steps from the first RUN cycle. One step = out high for width cycles, then low for width cycles.
- At the end of each high phase: position[i] += 1, or -= 1 when dir=1; remaining decrements.
- An axis is finished after the low phase of its last step; its out stays 0 and axes with 0 steps never pulse.
- RUN -> DONE in the cycle after the last low cycle of the slowest axis.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. busy=1 throughout SETUP and RUN only.
- dir is held from latch until the next trigger; it does not change in DONE or IDLE.
- en=0 in SETUP or RUN freezes all counters, phases and outputs (out holds its level), with no position updates; resumes on the exact next cycle.
- abort=1 in SETUP or RUN: next cycle out=0, state=DONE, done pulses. A partial high phase is not counted. abort is ignored in IDLE and DONE, and it overrides en=0.
- pos_clear zeroes position on the next edge. Same-edge precedence: pos_clear first, then that cycle's ±1 update, giving ±1.
- Position wraps modulo 2^POS_BITS; no saturation.
- Trigger in the DONE cycle is ignored.

Test Plan:
- NUM_AXES=2, DIR_SETUP_CYCLES=4; axis0 num=3 w=2, axis1 num=-2 w=5; trigger at cycle 0, en=1 -> dir=2'b10 and busy=1 from cycle 1; axis0 out high cycles 5-6, 9-10, 13-14; axis1 high 5-9, 15-19; done=1 only at cycle 25; position0=+3, position1=-2.
- All pulse_num=0 -> busy for 4 SETUP cycles; done at cycle 5; out never rises; position unchanged.
- pulse_num0=0x8000 (16-bit), w=1 -> exactly 32768 steps; position0 = -32768.
- Same move as first scenario with en=0 for cycles 6-9 -> all out edges after cycle 6 shift by 4 cycles; done at cycle 29; final positions unchanged.
- abort at cycle 7 of first scenario -> out=0 from cycle 8; done at cycle 8; position0=+1, position1=0; a following trigger is accepted in IDLE.
- pos_clear coincident with a high-phase end -> position equals ±1; pulse_width=0 behaves identically to 1; trigger while busy has no effect.
